// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier controller.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 4;
    localparam int unsigned CNT_W      = $clog2(MULT_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EVAL,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } mult_state_t;

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter: counts completed shifts and flags the final iteration.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          term_c
);

    // Last iteration reached; wrap is explicit so non-power-of-two widths work.
    assign term_c = (count == CW'(WIDTH - 1));

    // Count register: clear has priority, terminal increment wraps to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (term_c) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mult_seq_controller.sv
// Control FSM for the sequential shift-and-add multiplier datapath.
module mult_seq_controller
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     lq_lsb,
    output logic                     load,
    output logic                     acc_clr,
    output logic                     add_en,
    output logic                     shift,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH);

    mult_state_t state;
    mult_state_t next_state;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_term_c;

    mult_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (bit_cnt),
        .term_c (cnt_term_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and counter control; abort overrides every transition.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        unique case (state)
            ST_IDLE:  if (start) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_EVAL;
            ST_EVAL:  next_state = lq_lsb ? ST_ADD : ST_SHIFT;
            ST_ADD:   next_state = ST_SHIFT;
            ST_SHIFT: next_state = cnt_term_c ? ST_DONE : ST_EVAL;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase

        if (abort) begin
            next_state = ST_IDLE;
        end

        cnt_clr = ((state == ST_IDLE) && (next_state == ST_LOAD)) ||
                  (abort && (state != ST_IDLE));
        cnt_inc = (state == ST_SHIFT) && !abort;
    end

    // Strobes registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load    <= 1'b0;
            acc_clr <= 1'b0;
            add_en  <= 1'b0;
            shift   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            load    <= (next_state == ST_LOAD);
            acc_clr <= (next_state == ST_LOAD);
            add_en  <= (next_state == ST_ADD);
            shift   <= (next_state == ST_SHIFT);
            busy    <= (next_state != ST_IDLE);
            done    <= (next_state == ST_DONE);
        end
    end

endmodule

// File: doc/mult_seq_controller.md
# mult_seq_controller

Control FSM for the sequential shift-and-add multiplier. Given a start request, it drives load, accumulator-clear, add and shift strobes to the accumulator and LQ (multiplier) shift registers, one multiplier bit per iteration, and returns a single-cycle done pulse. It reads only the LSB of the LQ register and never touches operand data.

## Interface
- WIDTH, 4, operand width in bits (number of add/shift iterations); legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- start  in  1  multiply request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE without done.
- lq_lsb  in  1  bit 0 of the LQ register (current multiplier bit).
- load  out  1  loads the LQ and multiplicand registers from operand inputs.
- acc_clr  out  1  clears the accumulator and carry.
- add_en  out  1  loads the accumulator with accumulator + multiplicand (carry captured).
- shift  out  1  right-shifts {carry, accumulator, LQ} by one in the same cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse; product is valid in {accumulator, LQ}.
- bit_cnt  out  $clog2(WIDTH)  number of shifts completed in the current operation.

## Operation
- States: IDLE, LOAD, EVAL, ADD, SHIFT, DONE. All strobes are Moore outputs decoded from the state register.
- IDLE: all strobes are 0. On start=1, go to LOAD.
- LOAD: load=1 and acc_clr=1; bit_cnt is set to 0. Go to EVAL.
- EVAL: no strobe. If lq_lsb=1, go to ADD; otherwise go to SHIFT.
- ADD: add_en=1. Go to SHIFT.
- SHIFT: shift=1 and bit_cnt increments.
  - If bit_cnt == WIDTH-1 before the increment, go to DONE and wrap bit_cnt to 0.
  - Otherwise go to EVAL.
- DONE: done=1. Go to IDLE. start is not sampled in DONE.
- add_en and shift are never asserted in the same cycle. load and shift are never asserted in the same cycle.
- start while busy=1 is ignored; it is not queued.
- abort=1 in any non-IDLE state forces IDLE on the next edge, with no strobe decoded from the target state. abort overrides every transition, including DONE→IDLE, so no done pulse is produced. If abort and start are both 1 in IDLE, abort wins and the FSM stays in IDLE.
- Reset (rst=0), at any time including mid-operation: state becomes IDLE immediately. Outputs reset to load=0, acc_clr=0, add_en=0, shift=0, busy=0, done=0, bit_cnt=0. After rst rises, start is first sampled on the next edge.

## Timing
- Take the edge that samples start as cycle 0.
- LOAD is cycle 1.
- For each bit i: EVAL takes 1 cycle, ADD takes 1 cycle only if the bit is 1, SHIFT takes 1 cycle.
- done is high in cycle 2 + 2·WIDTH + popcount(multiplier).
  - WIDTH=4: 10 cycles minimum, 14 maximum.
- busy rises in cycle 1 and falls in the cycle after done.
- Back-to-back operation: start held high through DONE is first sampled in IDLE. The next LOAD therefore occurs 2 cycles after done.
- lq_lsb is sampled only in EVAL. It must be stable after the preceding LOAD or SHIFT edge; the datapath guarantees this because its registers update on the same edge.

## Structure
- Package mult_pkg:
  - state enum typedef mult_state_t.
  - default WIDTH constant.
  - localparam CNT_W = $clog2(WIDTH).
- Sub-module mult_bit_counter:
  - CNT_W-bit counter with synchronous clear and increment, and a terminal flag (count == WIDTH-1).
  - Same async active-low reset as this block.
- The FSM, next-state logic and output decode live in mult_seq_controller.

## Test plan
- WIDTH=4, lq_lsb model for multiplier 0000, start pulse → load/acc_clr in cycle 1, 4 shifts and no add_en, done in cycle 10, bit_cnt back to 0.
- Multiplier 1111 → 4 add_en pulses, each immediately followed by shift; done in cycle 14. Full datapath check: 15×15 gives product 225 (0xE1).
- Multiplier 0101, multiplicand 0011 → add_en in iterations 0 and 2 only; done in cycle 12; product 15.
- start re-pulsed in cycles 3 and 9, then held high through done → no restart while busy; the next LOAD occurs exactly 2 cycles after done.
- abort asserted in an ADD cycle → IDLE next cycle, no done pulse, busy=0. abort asserted in the DONE cycle → done still pulses in DONE and no further pulse follows.
- rst driven low asynchronously mid-SHIFT → all outputs 0 immediately. rst released and start given → a clean 10-cycle operation for multiplier 0000.
